// File: rtl/alu_issue_queue.sv
// ALU issue queue: DEPTH-entry FIFO of {op, a, b} with sticky illegal-opcode flag.
// Optional macro ALU_ISSUE_BYPASS_EN passes an entry straight through when the queue is empty.
module alu_issue_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [3:0]               in_op,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [3:0]               out_op,
    output logic [DATA_W-1:0]        out_a,
    output logic [DATA_W-1:0]        out_b,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     illegal_err,
    input  logic                     err_clr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0]    K_PASS_INPUTA = 4'h0;
    localparam logic [3:0]    K_OP_MAX      = 4'hC;
    localparam logic [CW-1:0] K_FULL        = CW'(DEPTH);

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          last_q, last_d;
    entry_t          in_entry, out_entry;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic            legal, empty, full, bypass, accept, push, pop;

    assign in_entry = {in_op, in_a, in_b};
    assign legal    = (in_op <= K_OP_MAX);
    assign empty    = (count_q == '0);
    assign full     = (count_q == K_FULL);

`ifdef ALU_ISSUE_BYPASS_EN
    assign bypass = empty && in_valid && legal && out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !empty || bypass;
    assign in_ready  = rst_n && (!full || (out_valid && out_ready));
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal && !bypass;
    assign pop       = !empty && out_ready;

    // When empty the outputs show the last entry handed to the ALU.
    always_comb begin
        out_entry = last_q;
        if (bypass) begin
            out_entry = in_entry;
        end else if (!empty) begin
            out_entry = mem_q[rd_ptr_q];
        end
    end

    assign out_op      = out_entry.op;
    assign out_a       = out_entry.a;
    assign out_b       = out_entry.b;
    assign count       = count_q;
    assign illegal_err = err_q;

    always_comb begin
        last_d   = last_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (out_valid && out_ready) begin
            last_d = out_entry;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        // A same-cycle illegal accept wins over the clear.
        if (accept && !legal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= '{op: K_PASS_INPUTA, a: '0, b: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            last_q   <= last_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: vector table, reset and latency sequences, random run vs queue model.
module tb_alu_issue_queue;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int W      = 4 + 2 * DATA_W;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
    logic [3:0]        in_op = 4'h0;
    logic [DATA_W-1:0] in_a = '0, in_b = '0;
    logic              in_ready, out_valid, illegal_err;
    logic [3:0]        out_op;
    logic [DATA_W-1:0] out_a, out_b;
    logic [$clog2(DEPTH):0] count;

    alu_issue_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .out_valid(out_valid), .out_op(out_op), .out_a(out_a), .out_b(out_b), .out_ready(out_ready),
        .count(count), .illegal_err(illegal_err), .err_clr(err_clr)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic ordy, input logic clr);
        @(posedge clk);
        #1;
        in_valid = v; in_op = op; in_a = a; in_b = b; out_ready = ordy; err_clr = clr;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 4'h0, 8'h00, 8'h00, ordy, 1'b0);
    endtask

    // scoreboard / reference model
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_last;
    logic         m_err;
    logic         m_ov, m_ir, m_byp;
    logic [W-1:0] m_head;

    task automatic model_reset();
        exp_q.delete();
        m_last = '0;
        m_err  = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 0; out_ready = 0; err_clr = 0; in_op = 0; in_a = 0; in_b = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic model_eval();
        logic is_legal;
        is_legal = (in_op <= 4'hC);
`ifdef ALU_ISSUE_BYPASS_EN
        m_byp = (exp_q.size() == 0) && in_valid && is_legal && out_ready;
`else
        m_byp = 1'b0;
`endif
        m_ov   = (exp_q.size() != 0) || m_byp;
        m_head = m_byp ? {in_op, in_a, in_b} : ((exp_q.size() != 0) ? exp_q[0] : m_last);
        m_ir   = (exp_q.size() < DEPTH) || (m_ov && out_ready);
    endtask

    task automatic model_step(output logic pushed_legal);
        logic acc, is_legal;
        is_legal = (in_op <= 4'hC);
        acc = in_valid && m_ir;
        pushed_legal = acc && is_legal;
        if (m_ov && out_ready) begin
            m_last = m_head;
            if (!m_byp) void'(exp_q.pop_front());
        end
        if (acc && is_legal && !m_byp) exp_q.push_back({in_op, in_a, in_b});
        if (acc && !is_legal) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [3:0] op;
        logic [7:0] a;
        logic       ordy;
        logic       clr;
        logic       e_ir;
        logic       e_ov;
        int         e_cnt;
        logic [3:0] e_op;
        logic [7:0] e_a;
        logic       e_err;
    } vec_t;

    function automatic vec_t mk(logic v, logic [3:0] op, logic [7:0] a, logic ordy, logic clr,
                                logic ir, logic ov, int cnt, logic [3:0] eop, logic [7:0] ea, logic err);
        vec_t r;
        r.v = v; r.op = op; r.a = a; r.ordy = ordy; r.clr = clr;
        r.e_ir = ir; r.e_ov = ov; r.e_cnt = cnt; r.e_op = eop; r.e_a = ea; r.e_err = err;
        return r;
    endfunction

    vec_t tbl [18];

    initial begin
        logic pl;
        int   legal_pushes;
        int   max_cnt;

        // fill/drain, full with push+pop, illegal opcode and err_clr priority
        tbl[0]  = mk(0, 4'h0, 8'd0,  0, 0,  1, 0, 0, 4'h0, 8'd0,  0);
        tbl[1]  = mk(1, 4'h5, 8'd10, 0, 0,  1, 0, 0, 4'h0, 8'd0,  0);
        tbl[2]  = mk(1, 4'h1, 8'd11, 0, 0,  1, 1, 1, 4'h5, 8'd10, 0);
        tbl[3]  = mk(1, 4'h2, 8'd12, 0, 0,  1, 1, 2, 4'h5, 8'd10, 0);
        tbl[4]  = mk(1, 4'h3, 8'd13, 0, 0,  1, 1, 3, 4'h5, 8'd10, 0);
        tbl[5]  = mk(0, 4'h0, 8'd0,  0, 0,  0, 1, 4, 4'h5, 8'd10, 0);
        tbl[6]  = mk(1, 4'hB, 8'd14, 1, 0,  1, 1, 4, 4'h5, 8'd10, 0);
        tbl[7]  = mk(0, 4'h0, 8'd0,  1, 0,  1, 1, 4, 4'h1, 8'd11, 0);
        tbl[8]  = mk(0, 4'h0, 8'd0,  1, 0,  1, 1, 3, 4'h2, 8'd12, 0);
        tbl[9]  = mk(0, 4'h0, 8'd0,  1, 0,  1, 1, 2, 4'h3, 8'd13, 0);
        tbl[10] = mk(0, 4'h0, 8'd0,  1, 0,  1, 1, 1, 4'hB, 8'd14, 0);
        tbl[11] = mk(0, 4'h0, 8'd0,  1, 0,  1, 0, 0, 4'hB, 8'd14, 0);
        tbl[12] = mk(1, 4'hE, 8'd1,  0, 0,  1, 0, 0, 4'hB, 8'd14, 0);
        tbl[13] = mk(1, 4'h8, 8'd2,  0, 0,  1, 0, 0, 4'hB, 8'd14, 1);
        tbl[14] = mk(0, 4'h0, 8'd0,  0, 1,  1, 1, 1, 4'h8, 8'd2,  1);
        tbl[15] = mk(0, 4'h0, 8'd0,  0, 0,  1, 1, 1, 4'h8, 8'd2,  0);
        tbl[16] = mk(1, 4'hE, 8'd3,  0, 1,  1, 1, 1, 4'h8, 8'd2,  0);
        tbl[17] = mk(0, 4'h0, 8'd0,  0, 0,  1, 1, 1, 4'h8, 8'd2,  1);

        do_reset();
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_count", 32'(count), 32'd0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].a, ~tbl[i].a, tbl[i].ordy, tbl[i].clr);
            #1;
            check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].e_ir});
            check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
            check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            check($sformatf("vec%0d_out_op", i), 32'(out_op), 32'(tbl[i].e_op));
            check($sformatf("vec%0d_out_a", i), 32'(out_a), 32'(tbl[i].e_a));
            check($sformatf("vec%0d_err", i), {31'b0, illegal_err}, {31'b0, tbl[i].e_err});
        end

        // reset pulsed between edges with three entries queued
        do_reset();
        drive(1, 4'h1, 8'd1, 8'd1, 0, 0);
        drive(1, 4'h2, 8'd2, 8'd2, 0, 0);
        drive(1, 4'h3, 8'd3, 8'd3, 0, 0);
        idle(0);
        #1 check("mid_count_before", 32'(count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        #1 rst_n = 1'b1;
        drive(1, 4'hC, 8'h5A, 8'hA5, 0, 0);
        idle(0);
        #1;
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd1);
        check("post_rst_head_op", 32'(out_op), 32'hC);
        check("post_rst_head_a", 32'(out_a), 32'h5A);
        check("post_rst_count", 32'(count), 32'd1);

        // entry latency into an empty queue with out_ready high
        do_reset();
        drive(1, 4'h5, 8'd3, 8'd4, 1, 0);
        #1;
`ifdef ALU_ISSUE_BYPASS_EN
        check("lat_same_cycle_valid", {31'b0, out_valid}, 32'd1);
        check("lat_same_cycle_op", 32'(out_op), 32'h5);
        check("lat_same_cycle_b", 32'(out_b), 32'd4);
`else
        check("lat_same_cycle_valid", {31'b0, out_valid}, 32'd0);
`endif
        check("lat_same_cycle_count", 32'(count), 32'd0);
        idle(1);
        #1;
`ifdef ALU_ISSUE_BYPASS_EN
        check("lat_next_valid", {31'b0, out_valid}, 32'd0);
        check("lat_next_count", 32'(count), 32'd0);
`else
        check("lat_next_valid", {31'b0, out_valid}, 32'd1);
        check("lat_next_op", 32'(out_op), 32'h5);
        check("lat_next_b", 32'(out_b), 32'd4);
        check("lat_next_count", 32'(count), 32'd1);
`endif

        // random traffic against the queue model
        do_reset();
        legal_pushes = 0;
        max_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
            drive(($urandom_range(0, 9) < 7), op, 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
            #1;
            model_eval();
            check("rnd_in_ready", {31'b0, in_ready}, {31'b0, m_ir});
            check("rnd_out_valid", {31'b0, out_valid}, {31'b0, m_ov});
            check("rnd_count", 32'(count), 32'(exp_q.size()));
            check("rnd_head", {12'b0, out_op, out_a, out_b}, {12'b0, m_head});
            check("rnd_err", {31'b0, illegal_err}, {31'b0, m_err});
            if (int'(count) > max_cnt) max_cnt = int'(count);
            model_step(pl);
            if (pl) legal_pushes++;
        end
        check("rnd_enough_pushes", {31'b0, (legal_pushes >= 3 * DEPTH + 1)}, 32'd1);
        check("rnd_count_bound", {31'b0, (max_cnt <= DEPTH)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream instruction present.
REQ-006 SHALL have port in_op  input  4  ALU opcode from the definitions package instruction map.
REQ-007 SHALL have port in_a, in_b  input  DATA_W each  operands.
REQ-008 SHALL have port in_ready  output  1  queue can accept this cycle.
REQ-009 SHALL have port out_valid  output  1  head entry presented to the ALU.
REQ-010 SHALL have port out_op / out_a / out_b  output  4 / DATA_W / DATA_W  head entry fields.
REQ-011 SHALL have port out_ready  input  1  ALU consumes the head this cycle.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-013 SHALL have port illegal_err  output  1  sticky; opcode outside 0x0..0xC was received.
REQ-014 SHALL have port err_clr  input  1  synchronous clear of illegal_err.

Function
REQ-015 SHALL accept an entry when in_valid && in_ready, and SHALL pop the head when out_valid && out_ready.
REQ-016 SHALL drive in_ready = (count < DEPTH) || (out_valid && out_ready); push while full is allowed only with a simultaneous pop.
REQ-017 SHALL drive out_valid = (count != 0); out_op/out_a/out_b SHALL come from the head register with no combinational path from in_*; entry-to-output latency is 1 cycle.
REQ-018 SHALL keep count unchanged on simultaneous push and pop, including when empty (no push to empty in bypass mode, see REQ-027) and when full.
REQ-019 SHALL wrap the read and write pointers modulo DEPTH, with no lost or duplicated entries.
REQ-020 SHALL drop opcodes 0xD..0xF: these opcodes are never enqueued, in_ready still asserts per REQ-016, and illegal_err is set on the next edge.
REQ-021 SHALL keep out_op/out_a/out_b stable while out_valid && !out_ready.
REQ-022 SHALL give err_clr priority below a same-cycle illegal accept: illegal_err is then 1.
REQ-023 SHALL hold out_* at the last-popped value when empty; values are don't-care when out_valid=0.

Reset
REQ-024 SHALL on rst_n=0, immediately and asynchronously, set count=0, pointers=0, out_valid=0, illegal_err=0, out_op=kPASS_INPUTA (4'b0000), out_a=0, out_b=0.
REQ-025 SHALL discard all queued entries on reset asserted mid-operation; the first accept after release SHALL occur no earlier than the first rising edge with rst_n=1.
REQ-026 SHALL keep in_ready=0 while rst_n=0.

Configuration
REQ-027 SHALL implement macro ALU_ISSUE_BYPASS_EN. When defined: if empty, in_valid, legal opcode and out_ready, the entry SHALL pass combinationally to out_* with out_valid=1 in the same cycle, and SHALL NOT be stored. When undefined: no in_*-to-out_* combinational path; latency is fixed at 1 cycle per REQ-017.

Verification
REQ-028 SHALL cover fill/drain: out_ready=0; push ops 5,1,2,3 with a=10..13. Response: in_ready=0 after the 4th push, count=4. Then out_ready=1: pops occur in order 5,1,2,3, count returns to 0.
REQ-029 SHALL cover full plus simultaneous push/pop: with count=4 and out_ready=1, push op 0xB. Response: accepted, count stays 4, 0xB exits 4 pops later.
REQ-030 SHALL cover illegal opcode: push op 0xE, then op 0x8. Response: only 0x8 is queued, illegal_err=1 from the next cycle; err_clr=1 then gives illegal_err=0.
REQ-031 SHALL cover reset mid-stream: with count=3, pulse rst_n low between edges. Response: out_valid=0 and count=0 immediately; the next push of op 0xC appears as the head.
REQ-032 SHALL cover pointer wrap: 3*DEPTH+1 random legal pushes with random out_ready. Response: output sequence equals input sequence, and count never exceeds DEPTH.
REQ-033 SHALL cover the bypass build with ALU_ISSUE_BYPASS_EN: empty queue, out_ready=1, push op 0x5 a=3 b=4. Response: out_valid=1 with out_op=0x5 in the same cycle, count stays 0. In the non-bypass build the same stimulus gives out_valid on the next cycle.
